synaptic_update_sequencer: RTL and testbench
============================================

Name: synaptic_update_sequencer

Overview:
- Controller stage directly upstream of synaptic_core; sequences one full FF-STDP training sweep after each sample's time window.
- Walks every (pre-neuron, post-neuron word) pair.
- Per pair: fetches the neuron spike counts, reads the weight and gradient SRAM words, then writes back the ffstdp-updated words.
- Drives synaptic_core's CTRL_* inputs and the neuron-memory read addresses; handshakes with the top-level controller via START/BUSY/DONE.

Parameters:
- INPUT_NEURON, 784, number of pre-neurons (rows).
- OUTPUT_NEURON, 256, number of post-neurons.
- POST_NEUR_PARALLEL, 4, post-neurons packed per SRAM word.
- PRE_NEUR_ADDR_WIDTH, 10, pre-neuron index width.
- POST_NEUR_WORD_ADDR_WIDTH, 8, post word index width.
- SYN_ARRAY_ADDR_WIDTH, 16, synaptic/gradient SRAM address width.

Ports:
- CLK  in  1  system clock, all logic rising-edge.
- RST  in  1  synchronous active-high reset.
- START  in  1  one-cycle request to begin a sweep.
- IS_TRAIN  in  1  sweep permitted only when high (sampled with START).
- BUSY  out  1  high from the first FETCH to the last WRITE inclusive.
- DONE  out  1  one-cycle pulse after the final write.
- CTRL_PRE_NEUR_CS  out  1  pre-neuron memory read enable.
- CTRL_PRE_NEUR_ADDR  out  PRE_NEUR_ADDR_WIDTH  current pre index.
- CTRL_POST_NEUR_CS  out  1  post-neuron memory read enable.
- CTRL_POST_NEUR_WORD_ADDR  out  POST_NEUR_WORD_ADDR_WIDTH  current post word.
- CTRL_SYNARRAY_CS  out  1  weight SRAM chip select.
- CTRL_SYNARRAY_WE  out  1  weight SRAM write enable.
- CTRL_SYNARRAY_ADDR  out  SYN_ARRAY_ADDR_WIDTH  weight/gradient SRAM address.
- CTRL_GRAD_ARRAY_CS  out  1  gradient SRAM chip select.
- CTRL_GRAD_ARRAY_WE  out  1  gradient SRAM write enable.
- CTRL_TREF_EVENT  out  1  update strobe to ffstdp_update; high only in WRITE.

Behaviour:
- Reset (synchronous, active-high; RST sampled each CLK edge):
  - state=IDLE, pre_idx=0, word_idx=0.
  - All outputs 0, including the address outputs.
  - RST mid-sweep aborts at the next edge: no further CS/WE, no DONE.
- Derived constants and address mapping:
  - WORDS = OUTPUT_NEURON/POST_NEUR_PARALLEL (64).
  - CTRL_SYNARRAY_ADDR = pre_idx*WORDS + word_idx.
  - Computed in SYN_ARRAY_ADDR_WIDTH bits; max 783*64+63 = 50175 (no overflow).
  - pre_idx is PRE_NEUR_ADDR_WIDTH bits; word_idx is POST_NEUR_WORD_ADDR_WIDTH bits.
- FSM states IDLE, FETCH, READ, WRITE, FINISH:
  - IDLE: START&&IS_TRAIN -> FETCH with counters=0. START with IS_TRAIN=0 is ignored and stays in IDLE.
  - FETCH (1 cycle): PRE_NEUR_CS=POST_NEUR_CS=1 with current indices. Spike counts are valid in the next cycle (1-cycle neuron SRAM latency). -> READ.
  - READ (1 cycle): SYNARRAY_CS=GRAD_ARRAY_CS=1, WE=0, address=current. -> WRITE.
  - WRITE (1 cycle):
    - SYNARRAY_CS/WE and GRAD_ARRAY_CS/WE all 1, same address as READ; CTRL_TREF_EVENT=1.
    - SRAM Q is valid this cycle; ffstdp is combinational, so the write data is the updated word.
    - Advance: if word_idx==WORDS-1 {word_idx=0; pre_idx++} else word_idx++.
    - If pre_idx==INPUT_NEURON-1 && word_idx==WORDS-1 -> FINISH, else -> FETCH.
  - FINISH (1 cycle): DONE=1, BUSY=0. -> IDLE.
- Address outputs hold their values through FETCH/READ/WRITE of a pair. In IDLE and FINISH they hold their last values; consumers must ignore them there.
- Outputs are registered, or decoded from the registered state only; no combinational path from START to any output.
- START while BUSY is ignored (no restart, no queueing).
- Sweep length: exactly 3*INPUT_NEURON*WORDS cycles of BUSY (150528 at defaults), plus 1 FINISH cycle.
- A START in the FINISH cycle is ignored; a START in the cycle after FINISH is accepted.

Decomposition:
- Shared package snn_ff_pkg holds:
  - FSM state encoding (3-bit localparams).
  - The WORDS derivation.
  - Default neuron/array widths, shared with synaptic_core.
- Natural sub-module: syn_addr_counter. Holds the nested pre/word counters and the row-major address, with inputs inc/clr and outputs pre_idx, word_idx, addr, last.
- The FSM stays in the top module.

Test Plan:
- Reset then idle: hold RST 3 cycles, no START -> all outputs 0, BUSY=0, no CS ever asserted.
- Single-sweep timing, INPUT_NEURON=2, OUTPUT_NEURON=8, PARALLEL=4 (WORDS=2); START&IS_TRAIN at cycle 0:
  - Addresses 0,1,2,3, each seen as FETCH, READ, WRITE.
  - DONE at cycle 13; BUSY high for exactly 12 cycles.
- Training gate: START with IS_TRAIN=0 -> stays IDLE, BUSY=0. START with IS_TRAIN=1 one cycle later -> sweep starts.
- Ignored START: pulse START at sweep cycle 5 -> address sequence unchanged, exactly one DONE.
- Mid-sweep reset: assert RST at cycle 7 -> next cycle all CS/WE=0 and BUSY=0, no DONE. A fresh START restarts at address 0.
- Default-size scoreboard: full 784x64 sweep with an SRAM model pre-filled with word=addr and ffstdp stubbed as +1 per byte:
  - Every word rewritten exactly once.
  - Final address 50175; DONE after 150528 BUSY cycles.

Source files
------------

// File: rtl/snn_ff_pkg.sv
// Shared definitions for the FF-STDP datapath: default array geometry,
// sequencer state encoding and the post-neuron word-count derivation.
package snn_ff_pkg;

  localparam int unsigned INPUT_NEURON_DEF              = 784;
  localparam int unsigned OUTPUT_NEURON_DEF             = 256;
  localparam int unsigned POST_NEUR_PARALLEL_DEF        = 4;
  localparam int unsigned PRE_NEUR_ADDR_WIDTH_DEF       = 10;
  localparam int unsigned POST_NEUR_WORD_ADDR_WIDTH_DEF = 8;
  localparam int unsigned SYN_ARRAY_ADDR_WIDTH_DEF      = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_READ   = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_FETCH  = ST_FETCH,
    S_READ   = ST_READ,
    S_WRITE  = ST_WRITE,
    S_FINISH = ST_FINISH
  } seq_state_e;

  // Number of SRAM words per pre-neuron row.
  function automatic int unsigned words_f(input int unsigned out_n, input int unsigned par);
    return out_n / par;
  endfunction

endpackage

// File: rtl/syn_addr_counter.sv
// Nested pre/word counters for the row-major synaptic sweep; the flat
// address is kept as its own register since row-major order just increments.
module syn_addr_counter
  import snn_ff_pkg::*;
#(
  parameter int unsigned ROWS   = INPUT_NEURON_DEF,
  parameter int unsigned WORDS  = OUTPUT_NEURON_DEF / POST_NEUR_PARALLEL_DEF,
  parameter int unsigned PRE_W  = PRE_NEUR_ADDR_WIDTH_DEF,
  parameter int unsigned WORD_W = POST_NEUR_WORD_ADDR_WIDTH_DEF,
  parameter int unsigned ADDR_W = SYN_ARRAY_ADDR_WIDTH_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [PRE_W-1:0]  pre_idx_o,
  output logic [WORD_W-1:0] word_idx_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [PRE_W-1:0]  pre_q;
  logic [WORD_W-1:0] word_q;
  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      pre_q  <= '0;
      word_q <= '0;
      addr_q <= '0;
    end else if (inc_i) begin
      addr_q <= addr_q + ADDR_W'(1);
      if (word_q == WORD_W'(WORDS - 1)) begin
        word_q <= '0;
        pre_q  <= pre_q + PRE_W'(1);
      end else begin
        word_q <= word_q + WORD_W'(1);
      end
    end
  end

  assign pre_idx_o  = pre_q;
  assign word_idx_o = word_q;
  assign addr_o     = addr_q;
  assign last_o     = (pre_q == PRE_W'(ROWS - 1)) && (word_q == WORD_W'(WORDS - 1));

endmodule

// File: rtl/synaptic_update_sequencer.sv
// Sequences one FF-STDP training sweep: FETCH spike counts, READ weight and
// gradient words, WRITE the updated words, for every (pre, post word) pair.
module synaptic_update_sequencer
  import snn_ff_pkg::*;
#(
  parameter int unsigned INPUT_NEURON              = INPUT_NEURON_DEF,
  parameter int unsigned OUTPUT_NEURON             = OUTPUT_NEURON_DEF,
  parameter int unsigned POST_NEUR_PARALLEL        = POST_NEUR_PARALLEL_DEF,
  parameter int unsigned PRE_NEUR_ADDR_WIDTH       = PRE_NEUR_ADDR_WIDTH_DEF,
  parameter int unsigned POST_NEUR_WORD_ADDR_WIDTH = POST_NEUR_WORD_ADDR_WIDTH_DEF,
  parameter int unsigned SYN_ARRAY_ADDR_WIDTH      = SYN_ARRAY_ADDR_WIDTH_DEF
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 START,
  input  logic                                 IS_TRAIN,
  output logic                                 BUSY,
  output logic                                 DONE,
  output logic                                 CTRL_PRE_NEUR_CS,
  output logic [PRE_NEUR_ADDR_WIDTH-1:0]       CTRL_PRE_NEUR_ADDR,
  output logic                                 CTRL_POST_NEUR_CS,
  output logic [POST_NEUR_WORD_ADDR_WIDTH-1:0] CTRL_POST_NEUR_WORD_ADDR,
  output logic                                 CTRL_SYNARRAY_CS,
  output logic                                 CTRL_SYNARRAY_WE,
  output logic [SYN_ARRAY_ADDR_WIDTH-1:0]      CTRL_SYNARRAY_ADDR,
  output logic                                 CTRL_GRAD_ARRAY_CS,
  output logic                                 CTRL_GRAD_ARRAY_WE,
  output logic                                 CTRL_TREF_EVENT
);

  localparam int unsigned WORDS = words_f(OUTPUT_NEURON, POST_NEUR_PARALLEL);

  seq_state_e state_q;
  logic busy_q, done_q, neur_cs_q, arr_cs_q, arr_we_q;
  logic cnt_clr, cnt_inc, cnt_last;

  assign cnt_clr = (state_q == S_IDLE) && START && IS_TRAIN;
  assign cnt_inc = (state_q == S_WRITE) && !cnt_last;

  syn_addr_counter #(
    .ROWS   (INPUT_NEURON),
    .WORDS  (WORDS),
    .PRE_W  (PRE_NEUR_ADDR_WIDTH),
    .WORD_W (POST_NEUR_WORD_ADDR_WIDTH),
    .ADDR_W (SYN_ARRAY_ADDR_WIDTH)
  ) u_cnt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .clr_i      (cnt_clr),
    .inc_i      (cnt_inc),
    .pre_idx_o  (CTRL_PRE_NEUR_ADDR),
    .word_idx_o (CTRL_POST_NEUR_WORD_ADDR),
    .addr_o     (CTRL_SYNARRAY_ADDR),
    .last_o     (cnt_last)
  );

  // Outputs are loaded together with the state they belong to.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      neur_cs_q <= 1'b0;
      arr_cs_q  <= 1'b0;
      arr_we_q  <= 1'b0;
    end else begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      neur_cs_q <= 1'b0;
      arr_cs_q  <= 1'b0;
      arr_we_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START && IS_TRAIN) begin
            state_q   <= S_FETCH;
            busy_q    <= 1'b1;
            neur_cs_q <= 1'b1;
          end
        end
        S_FETCH: begin
          state_q  <= S_READ;
          busy_q   <= 1'b1;
          arr_cs_q <= 1'b1;
        end
        S_READ: begin
          state_q  <= S_WRITE;
          busy_q   <= 1'b1;
          arr_cs_q <= 1'b1;
          arr_we_q <= 1'b1;
        end
        S_WRITE: begin
          if (cnt_last) begin
            state_q <= S_FINISH;
            done_q  <= 1'b1;
          end else begin
            state_q   <= S_FETCH;
            busy_q    <= 1'b1;
            neur_cs_q <= 1'b1;
          end
        end
        S_FINISH: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign BUSY               = busy_q;
  assign DONE               = done_q;
  assign CTRL_PRE_NEUR_CS   = neur_cs_q;
  assign CTRL_POST_NEUR_CS  = neur_cs_q;
  assign CTRL_SYNARRAY_CS   = arr_cs_q;
  assign CTRL_SYNARRAY_WE   = arr_we_q;
  assign CTRL_GRAD_ARRAY_CS = arr_cs_q;
  assign CTRL_GRAD_ARRAY_WE = arr_we_q;
  assign CTRL_TREF_EVENT    = arr_we_q;

endmodule

// File: tb/tb_synaptic_update_sequencer.sv
// Bench for synaptic_update_sequencer: a 2x2-word instance for timing and
// control corner cases, and a 5x6-word instance driving an SRAM model.
module tb_synaptic_update_sequencer;

  localparam int unsigned M_ROWS  = 5;
  localparam int unsigned M_WORDS = 6;
  localparam int unsigned M_PAIRS = M_ROWS * M_WORDS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // small instance
  logic rst_s, start_s, train_s;
  logic busy_s, done_s, pre_cs_s, post_cs_s, syn_cs_s, syn_we_s, grad_cs_s, grad_we_s, tref_s;
  logic [9:0]  pre_addr_s;
  logic [7:0]  post_addr_s;
  logic [15:0] syn_addr_s;

  synaptic_update_sequencer #(
    .INPUT_NEURON(2), .OUTPUT_NEURON(8), .POST_NEUR_PARALLEL(4)
  ) dut_s (
    .CLK(clk), .RST(rst_s), .START(start_s), .IS_TRAIN(train_s),
    .BUSY(busy_s), .DONE(done_s),
    .CTRL_PRE_NEUR_CS(pre_cs_s), .CTRL_PRE_NEUR_ADDR(pre_addr_s),
    .CTRL_POST_NEUR_CS(post_cs_s), .CTRL_POST_NEUR_WORD_ADDR(post_addr_s),
    .CTRL_SYNARRAY_CS(syn_cs_s), .CTRL_SYNARRAY_WE(syn_we_s), .CTRL_SYNARRAY_ADDR(syn_addr_s),
    .CTRL_GRAD_ARRAY_CS(grad_cs_s), .CTRL_GRAD_ARRAY_WE(grad_we_s), .CTRL_TREF_EVENT(tref_s)
  );

  // medium instance
  logic rst_m, start_m, train_m;
  logic busy_m, done_m, pre_cs_m, post_cs_m, syn_cs_m, syn_we_m, grad_cs_m, grad_we_m, tref_m;
  logic [9:0]  pre_addr_m;
  logic [7:0]  post_addr_m;
  logic [15:0] syn_addr_m;

  synaptic_update_sequencer #(
    .INPUT_NEURON(M_ROWS), .OUTPUT_NEURON(M_WORDS * 4), .POST_NEUR_PARALLEL(4)
  ) dut_m (
    .CLK(clk), .RST(rst_m), .START(start_m), .IS_TRAIN(train_m),
    .BUSY(busy_m), .DONE(done_m),
    .CTRL_PRE_NEUR_CS(pre_cs_m), .CTRL_PRE_NEUR_ADDR(pre_addr_m),
    .CTRL_POST_NEUR_CS(post_cs_m), .CTRL_POST_NEUR_WORD_ADDR(post_addr_m),
    .CTRL_SYNARRAY_CS(syn_cs_m), .CTRL_SYNARRAY_WE(syn_we_m), .CTRL_SYNARRAY_ADDR(syn_addr_m),
    .CTRL_GRAD_ARRAY_CS(grad_cs_m), .CTRL_GRAD_ARRAY_WE(grad_we_m), .CTRL_TREF_EVENT(tref_m)
  );

  logic [6:0]  ctrl_s;
  logic [42:0] obs_s;
  assign ctrl_s = {pre_cs_s, post_cs_s, syn_cs_s, syn_we_s, grad_cs_s, grad_we_s, tref_s};
  assign obs_s  = {busy_s, done_s, ctrl_s, pre_addr_s, post_addr_s, syn_addr_s};

  localparam logic [6:0] C_FETCH = 7'b1100000;
  localparam logic [6:0] C_READ  = 7'b0010100;
  localparam logic [6:0] C_WRITE = 7'b0011111;

  typedef struct packed {
    logic [6:0]  ctrl;
    logic [15:0] addr;
    logic [9:0]  pre;
    logic [7:0]  word;
  } exp_t;
  exp_t exp_q[$];

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t wr_q[$];

  // ffstdp stub: every byte of the word incremented by one
  function automatic logic [31:0] bytes_inc(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*b +: 8] + 8'd1;
    return r;
  endfunction

  // SRAM model for the medium instance: 1-cycle read latency
  logic        fill_m = 1'b0;
  logic [31:0] mem_m [M_PAIRS];
  int          wr_cnt_m [M_PAIRS];
  logic [31:0] q_m;
  logic [31:0] wdata_m;
  assign wdata_m = bytes_inc(q_m);

  always @(posedge clk) begin
    if (fill_m) begin
      for (int i = 0; i < M_PAIRS; i++) begin
        mem_m[i]    <= 32'(i);
        wr_cnt_m[i] <= 0;
      end
      q_m <= '0;
    end else if (syn_cs_m && 32'(syn_addr_m) < M_PAIRS) begin
      if (syn_we_m) begin
        mem_m[syn_addr_m]    <= wdata_m;
        wr_cnt_m[syn_addr_m] <= wr_cnt_m[syn_addr_m] + 1;
      end else begin
        q_m <= mem_m[syn_addr_m];
      end
    end
  end

  // One sweep on the small instance; optional stray START / mid-sweep RST.
  task automatic run_small(input int extra_at, input int rst_at);
    int busy_cnt, done_cnt, done_cyc;
    exp_t e;
    exp_q.delete();
    for (int a = 0; a < 4; a++) begin
      exp_q.push_back('{C_FETCH, 16'(a), 10'(a / 2), 8'(a % 2)});
      exp_q.push_back('{C_READ,  16'(a), 10'(a / 2), 8'(a % 2)});
      exp_q.push_back('{C_WRITE, 16'(a), 10'(a / 2), 8'(a % 2)});
    end
    busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    train_s = 1'b1;
    start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start_s = (n == extra_at);
      rst_s   = (n == rst_at);
      if (rst_at > 0 && n == rst_at + 1) begin
        total_cnt++;
        if (obs_s !== 43'd0) $display("FAIL mid_reset_outputs: got %h want 0", obs_s);
        else pass_cnt++;
      end
      if (busy_s === 1'b1) begin
        busy_cnt++;
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL sweep_extra_busy: cycle %0d busy with no pair pending", n);
        end else begin
          e = exp_q.pop_front();
          if ({ctrl_s, syn_addr_s, pre_addr_s, post_addr_s} !== e)
            $display("FAIL sweep_step cycle %0d: got ctrl=%b addr=%0d pre=%0d word=%0d want ctrl=%b addr=%0d pre=%0d word=%0d",
                     n, ctrl_s, syn_addr_s, pre_addr_s, post_addr_s, e.ctrl, e.addr, e.pre, e.word);
          else pass_cnt++;
        end
      end
      if (done_s === 1'b1) begin
        done_cnt++;
        done_cyc = n;
        total_cnt++;
        if ({busy_s, ctrl_s} !== 8'd0) $display("FAIL finish_quiet: got busy/ctrl=%b want 0", {busy_s, ctrl_s});
        else pass_cnt++;
      end
    end
    start_s = 1'b0;
    rst_s   = 1'b0;
    if (rst_at == 0) begin
      total_cnt++;
      if (busy_cnt != 12) $display("FAIL busy_cycles: got %0d want 12", busy_cnt);
      else pass_cnt++;
      total_cnt++;
      if (done_cnt != 1 || done_cyc != 13) $display("FAIL done_pulse: got count=%0d cycle=%0d want count=1 cycle=13", done_cnt, done_cyc);
      else pass_cnt++;
    end else begin
      total_cnt++;
      if (done_cnt != 0 || busy_cnt != rst_at)
        $display("FAIL mid_reset_abort: got done=%0d busy=%0d want done=0 busy=%0d", done_cnt, busy_cnt, rst_at);
      else pass_cnt++;
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_s = 1'b1; rst_m = 1'b1;
    start_s = 1'b0; start_m = 1'b0; train_s = 1'b0; train_m = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (n == 2) begin rst_s = 1'b0; rst_m = 1'b0; end
      total_cnt++;
      if (obs_s !== 43'd0) $display("FAIL reset_idle cycle %0d: got %h want 0", n, obs_s);
      else pass_cnt++;
    end
  endtask

  task automatic test_single_sweep();
    run_small(0, 0);
  endtask

  task automatic test_train_gate();
    train_s = 1'b0;
    start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({busy_s, done_s, ctrl_s} !== 9'd0) $display("FAIL train_gate: got %b want 0", {busy_s, done_s, ctrl_s});
    else pass_cnt++;
    run_small(0, 0);
  endtask

  task automatic test_ignored_start();
    run_small(5, 0);
  endtask

  task automatic test_mid_reset();
    run_small(0, 7);
    run_small(0, 0);
  endtask

  task automatic test_scoreboard_sweep();
    int busy_cnt, done_cnt, done_cyc;
    logic [15:0] done_addr;
    wr_t w;
    fill_m = 1'b1;
    @(negedge clk);
    fill_m = 1'b0;
    wr_q.delete();
    for (int a = 0; a < M_PAIRS; a++) wr_q.push_back('{16'(a), bytes_inc(32'(a))});
    busy_cnt = 0; done_cnt = 0; done_cyc = -1; done_addr = '0;
    train_m = 1'b1;
    start_m = 1'b1;
    @(posedge clk);
    #1 start_m = 1'b0;
    for (int n = 1; n <= 3 * M_PAIRS + 20; n++) begin
      @(negedge clk);
      if (busy_m === 1'b1) busy_cnt++;
      if (syn_cs_m === 1'b1 && syn_we_m === 1'b1) begin
        total_cnt++;
        if (wr_q.size() == 0) begin
          $display("FAIL sb_extra_write: addr=%0d", syn_addr_m);
        end else begin
          w = wr_q.pop_front();
          if ({syn_addr_m, wdata_m} !== w)
            $display("FAIL sb_write: got addr=%0d data=%h want addr=%0d data=%h", syn_addr_m, wdata_m, w.addr, w.data);
          else pass_cnt++;
        end
      end
      if (done_m === 1'b1) begin
        done_cnt++;
        done_cyc = n;
        done_addr = syn_addr_m;
      end
    end
    total_cnt++;
    if (done_cnt != 1 || done_cyc != 3 * M_PAIRS + 1 || busy_cnt != 3 * M_PAIRS)
      $display("FAIL sb_timing: got done=%0d at %0d busy=%0d want done=1 at %0d busy=%0d",
               done_cnt, done_cyc, busy_cnt, 3 * M_PAIRS + 1, 3 * M_PAIRS);
    else pass_cnt++;
    total_cnt++;
    if (done_addr !== 16'(M_PAIRS - 1)) $display("FAIL sb_final_addr: got %0d want %0d", done_addr, M_PAIRS - 1);
    else pass_cnt++;
    total_cnt++;
    if (wr_q.size() != 0) $display("FAIL sb_missing_writes: got %0d pending want 0", wr_q.size());
    else pass_cnt++;
    for (int a = 0; a < M_PAIRS; a++) begin
      total_cnt++;
      if (mem_m[a] !== bytes_inc(32'(a)) || wr_cnt_m[a] != 1)
        $display("FAIL sb_mem[%0d]: got data=%h writes=%0d want data=%h writes=1", a, mem_m[a], wr_cnt_m[a], bytes_inc(32'(a)));
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single_sweep();
    test_train_gate();
    test_ignored_start();
    test_mid_reset();
    test_scoreboard_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
